// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default baud divider.
package uart_pkg;

    // 300 MHz system clock / 115200 baud.
    localparam int BAUD_DIV_115200 = 2604;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a pop and a push in the same cycle are legal even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, optional parity, break handling, sticky
// error flags and a receive FIFO that the receiver never waits on.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = BAUD_DIV_115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          RX,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rdy,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frm_err,
    output logic                          par_err,
    output logic                          ovr_err
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    logic                 rx_meta;
    logic                 rx_s;

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 push_q, push_d;
    logic                 frm_set_q, frm_set_d;
    logic                 par_set_q, par_set_d;
    logic                 tick;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 ovr_set;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (cnt_q == '0);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        push_d    = 1'b0;
        frm_set_d = 1'b0;
        par_set_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end

            RX_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    state_d   = RX_DATA;
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = '0;
                    par_bad_d = 1'b0;
                end else begin
                    state_d = RX_IDLE;
                end
            end

            RX_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            RX_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_bad_d = (rx_s != ((^shift_q) ^ ODD_BIT));
                    state_d   = RX_STOP;
                    cnt_d     = FULL_LOAD;
                end
            end

            RX_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_set_d = par_bad_q;
                    if (rx_s) begin
                        state_d = RX_IDLE;
                        push_d  = !par_bad_q;
                    end else begin
                        frm_set_d = 1'b1;
                        state_d   = RX_BREAK;
                    end
                end
            end

            RX_BREAK: begin
                // Hold off until the line returns high so a long break yields one error only.
                if (rx_s) state_d = RX_IDLE;
            end

            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            push_q    <= 1'b0;
            frm_set_q <= 1'b0;
            par_set_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            push_q    <= push_d;
            frm_set_q <= frm_set_d;
            par_set_q <= par_set_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (rd_en),
        .wdata (shift_q),
        .rdata (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign rdy     = !fifo_empty;
    assign ovr_set = push_q && fifo_full && !rd_en;

    // Set wins over clear so an error arriving with clr_err is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_err <= 1'b0;
            par_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            frm_err <= (frm_err && !clr_err) || frm_set_q;
            par_err <= (par_err && !clr_err) || par_set_q;
            ovr_err <= (ovr_err && !clr_err) || ovr_set;
        end
    end

endmodule
